// File: rtl/gate_pkg.sv
// Shared opcode constants and FSM state encoding for the gate sweep unit.
package gate_pkg;

    localparam logic [2:0] GOP_AND  = 3'd0;
    localparam logic [2:0] GOP_OR   = 3'd1;
    localparam logic [2:0] GOP_XOR  = 3'd2;
    localparam logic [2:0] GOP_NAND = 3'd3;
    localparam logic [2:0] GOP_NOR  = 3'd4;
    localparam logic [2:0] GOP_XNOR = 3'd5;
    localparam logic [2:0] GOP_BUF  = 3'd6;
    localparam logic [2:0] GOP_NOT  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

endpackage

// File: rtl/gate_reduce.sv
// Combinational N-input reduction gate selected by a 3-bit opcode.
module gate_reduce
    import gate_pkg::*;
#(
    parameter int N_IN = 4
) (
    input  logic [2:0]      op,
    input  logic [N_IN-1:0] vec,
    output logic            y
);

    always_comb begin
        // NOTE: default first so every path assigns y and no latch is inferred.
        y = 1'b0;
        case (op)
            GOP_AND:  y = &vec;
            GOP_OR:   y = |vec;
            GOP_XOR:  y = ^vec;
            GOP_NAND: y = ~&vec;
            GOP_NOR:  y = ~|vec;
            GOP_XNOR: y = ~^vec;
            GOP_BUF:  y = vec[0];
            GOP_NOT:  y = ~vec[0];
        endcase
    end

endmodule

// File: rtl/gate_sweep_unit.sv
// Self-exercising gate unit: sweeps all input vectors through one reduction gate
// and builds its truth table. Optional ones_count port via GATE_SWEEP_POPCOUNT_EN.
module gate_sweep_unit
    import gate_pkg::*;
#(
    parameter  int N_IN = 4,
    localparam int TT_W = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [2:0]      op,
    output logic            busy,
    output logic            done,
    output logic            vec_valid,
    output logic [N_IN-1:0] vec_out,
    output logic            res_out,
    output logic [TT_W-1:0] truth_table
`ifdef GATE_SWEEP_POPCOUNT_EN
    ,
    output logic [N_IN:0]   ones_count
`endif
);

    state_t          state;
    logic [2:0]      op_q;
    logic [N_IN-1:0] cnt;
    logic            y;

    gate_reduce #(.N_IN(N_IN)) u_reduce (
        .op  (op_q),
        .vec (cnt),
        .y   (y)
    );

    // NOTE: every register here is state, so all updates are non-blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= GOP_AND;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            vec_valid   <= 1'b0;
            vec_out     <= '0;
            res_out     <= 1'b0;
            truth_table <= '0;
`ifdef GATE_SWEEP_POPCOUNT_EN
            ones_count  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_SWEEP;
                        op_q        <= op;
                        cnt         <= '0;
                        truth_table <= '0;
                        busy        <= 1'b1;
`ifdef GATE_SWEEP_POPCOUNT_EN
                        ones_count  <= '0;
`endif
                    end
                end
                ST_SWEEP: begin
                    // Abort wins over the write, including on the final vector.
                    if (abort) begin
                        state     <= ST_ABORT;
                        busy      <= 1'b0;
                        vec_valid <= 1'b0;
                    end else begin
                        vec_out          <= cnt;
                        res_out          <= y;
                        truth_table[cnt] <= y;
                        vec_valid        <= 1'b1;
                        cnt              <= cnt + N_IN'(1);
`ifdef GATE_SWEEP_POPCOUNT_EN
                        ones_count       <= ones_count + (N_IN + 1)'(y);
`endif
                        if (cnt == '1) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    done      <= 1'b0;
                    vec_valid <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Bench for gate_sweep_unit: directed and randomized sweeps at N_IN=4, plus
// NAND sweeps at N_IN=2 and N_IN=6 against a truth-table reference model.
module tb_gate_sweep_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [2:0]  op;
    logic        busy, done, vec_valid, res_out;
    logic [3:0]  vec_out;
    logic [15:0] truth_table;

    logic        s_start;
    logic [2:0]  s_op;
    logic        busy2, done2, vv2, res2;
    logic [1:0]  vo2;
    logic [3:0]  tt2;
    logic        busy6, done6, vv6, res6;
    logic [5:0]  vo6;
    logic [63:0] tt6;
`ifdef GATE_SWEEP_POPCOUNT_EN
    logic [4:0]  ones_count;
    logic [2:0]  oc2;
    logic [6:0]  oc6;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gate_sweep_unit #(.N_IN(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op(op),
        .busy(busy), .done(done), .vec_valid(vec_valid), .vec_out(vec_out),
        .res_out(res_out), .truth_table(truth_table)
`ifdef GATE_SWEEP_POPCOUNT_EN
        , .ones_count(ones_count)
`endif
    );

    gate_sweep_unit #(.N_IN(2)) dut2 (
        .clk(clk), .reset(reset), .start(s_start), .abort(1'b0), .op(s_op),
        .busy(busy2), .done(done2), .vec_valid(vv2), .vec_out(vo2),
        .res_out(res2), .truth_table(tt2)
`ifdef GATE_SWEEP_POPCOUNT_EN
        , .ones_count(oc2)
`endif
    );

    gate_sweep_unit #(.N_IN(6)) dut6 (
        .clk(clk), .reset(reset), .start(s_start), .abort(1'b0), .op(s_op),
        .busy(busy6), .done(done6), .vec_valid(vv6), .vec_out(vo6),
        .res_out(res6), .truth_table(tt6)
`ifdef GATE_SWEEP_POPCOUNT_EN
        , .ones_count(oc6)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Gate result from the count of ones in the vector.
    function automatic bit ref_gate(input int o, input int v, input int n);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += (v >> i) & 1;
        case (o)
            0: return ones == n;
            1: return ones != 0;
            2: return (ones % 2) == 1;
            3: return ones != n;
            4: return ones == 0;
            5: return (ones % 2) == 0;
            6: return (v % 2) == 1;
            default: return (v % 2) == 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_table(input int o, input int n, input int written);
        logic [63:0] t = '0;
        for (int k = 0; k < written; k++) t[k] = ref_gate(o, k, n);
        return t;
    endfunction

    function automatic int popc(input logic [63:0] t);
        int c = 0;
        for (int i = 0; i < 64; i++) c += int'(t[i]);
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // One N_IN=4 sweep; n_ok vectors complete before abort (16 = no abort).
    task automatic sweep4(input int o, input int n_ok, input bit mid_start);
        logic [63:0] exp_tt;
        start = 1'b1;
        op    = 3'(o);
        tick();
        start = 1'b0;
        op    = 3'($urandom_range(0, 7));
        check("busy_after_start", busy, 1'b1);
        check("vv_after_start", vec_valid, 1'b0);
        for (int k = 0; k < n_ok; k++) begin
            tick();
            start = 1'b0;
            op    = 3'($urandom_range(0, 7));
            check("vec_valid", vec_valid, 1'b1);
            check("vec_out", vec_out, 64'(k));
            check("res_out", res_out, ref_gate(o, k, 4));
            check("done_timing", done, k == 15);
            check("busy_timing", busy, k != 15);
            if (mid_start && k == 7) start = 1'b1;
        end
        if (n_ok < 16) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_vv", vec_valid, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_done", done, 1'b0);
            if (n_ok > 0) check("abort_vec_hold", vec_out, 64'(n_ok - 1));
        end
        tick();
        check("end_done", done, 1'b0);
        check("end_vv", vec_valid, 1'b0);
        check("end_busy", busy, 1'b0);
        exp_tt = ref_table(o, 4, n_ok);
        check("truth_table", truth_table, exp_tt);
`ifdef GATE_SWEEP_POPCOUNT_EN
        check("ones_count", ones_count, 64'(popc(exp_tt)));
`endif
    endtask

    initial begin
        int lat2, lat6, ndone2, ndone6;
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        op      = 3'd0;
        s_start = 1'b0;
        s_op    = 3'd0;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_vv", vec_valid, 1'b0);
        check("rst_vec", vec_out, 0);
        check("rst_res", res_out, 1'b0);
        check("rst_tt", truth_table, 0);
`ifdef GATE_SWEEP_POPCOUNT_EN
        check("rst_ones", ones_count, 0);
`endif
        tick();
        reset = 1'b0;
        tick();

        sweep4(0, 16, 1'b0);
        check("and_const", truth_table, 64'h8000);
        sweep4(2, 16, 1'b0);
        check("xor_const", truth_table, 64'h6996);
        sweep4(4, 16, 1'b0);
        check("nor_const", truth_table, 64'h0001);
        sweep4(7, 16, 1'b0);
        check("not_const", truth_table, 64'h5555);
        sweep4(1, 16, 1'b1);
        check("or_mid_const", truth_table, 64'hFFFE);
        sweep4(1, 5, 1'b0);
        check("abort5_const", truth_table, 64'h001E);
        sweep4(3, 15, 1'b0);
        check("abort_last_const", truth_table, 64'h7FFF);

        // Reset in the middle of a sweep, checked before the next clock edge.
        start = 1'b1;
        op    = 3'd1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("pre_reset_vec", vec_out, 7);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_vv", vec_valid, 1'b0);
        check("arst_vec", vec_out, 0);
        check("arst_res", res_out, 1'b0);
        check("arst_tt", truth_table, 0);
`ifdef GATE_SWEEP_POPCOUNT_EN
        check("arst_ones", ones_count, 0);
`endif
        tick();
        reset = 1'b0;
        tick();
        sweep4(1, 16, 1'b0);

        for (int r = 0; r < 8; r++) begin
            int o, n;
            o = int'($urandom_range(0, 7));
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 16;
            sweep4(o, n, 1'($urandom_range(0, 1)));
        end

        // N_IN=2 and N_IN=6 NAND sweeps run side by side.
        lat2 = -1; lat6 = -1; ndone2 = 0; ndone6 = 0;
        s_start = 1'b1;
        s_op    = 3'd3;
        tick();
        s_start = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            tick();
            if (done2) begin
                ndone2++;
                if (lat2 < 0) lat2 = i;
            end
            if (done6) begin
                ndone6++;
                if (lat6 < 0) lat6 = i;
            end
        end
        check("n2_latency", 64'(lat2), 4);
        check("n6_latency", 64'(lat6), 64);
        check("n2_done_count", 64'(ndone2), 1);
        check("n6_done_count", 64'(ndone6), 1);
        check("n2_tt", tt2, ref_table(3, 2, 4));
        check("n6_tt", tt6, ref_table(3, 6, 64));
        check("n6_tt_const", tt6, 64'h7FFF_FFFF_FFFF_FFFF);
`ifdef GATE_SWEEP_POPCOUNT_EN
        check("n2_ones", oc2, 3);
        check("n6_ones", oc6, 63);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
